// File: rtl/alu_iter.sv
// alu_iter: execution-side ALU driven by the 4-bit ALU control code.
// Logic ops, add/sub and set-less-than finish in one cycle. MUL uses an
// iterative shift-add sequence with a fixed latency of WIDTH iterations.
// Requests come in and results go out through valid/ready handshakes.
// ready_o and valid_o are registered so that the pipeline can stall on them.

module alu_iter #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             err_o,
  output logic             valid_o,
  input  logic             ready_i
);

  // Operation codes produced by the ALU control decoder
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  // The counter value on the final MUL iteration
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  // IDLE waits for a request, MUL iterates, DONE holds the result until it is taken
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_err;
  logic             r_valid;
  logic             r_ready;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_opResult;
  logic             w_opIllegal;
  logic             w_opIsMul;
  logic             w_srcLess;
  logic [WIDTH-1:0] w_accNext;
  logic             w_lastIter;

  assign w_srcLess  = ($signed(src1_i) < $signed(src2_i));
  assign w_lastIter = (r_cnt == LAST_ITER);

  // Single-cycle result for the code on the inputs; illegal codes yield zero and set the error flag
  always_comb begin
    w_opResult  = '0;
    w_opIllegal = 1'b0;
    w_opIsMul   = 1'b0;
    case (ALUCtrl_i)
      OP_AND:  w_opResult = src1_i & src2_i;
      OP_OR:   w_opResult = src1_i | src2_i;
      OP_ADD:  w_opResult = src1_i + src2_i;
      OP_SUB:  w_opResult = src1_i - src2_i;
      OP_SLT:  w_opResult = {{(WIDTH-1){1'b0}}, w_srcLess};
      OP_MUL:  w_opIsMul  = 1'b1;
      default: w_opIllegal = 1'b1;
    endcase
  end

  // One shift-add step: the shifted multiplicand is added when the current multiplier bit is set
  always_comb begin
    w_accNext = r_acc;
    if (r_mplier[0]) begin
      w_accNext = r_acc + r_mcand;
    end
  end

  // Control FSM with registered handshake outputs, result registers and multiplier datapath
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
      r_valid  <= 1'b0;
      r_ready  <= 1'b1;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_ready <= 1'b0;
            if (w_opIsMul) begin
              r_mcand  <= src1_i;
              r_mplier <= src2_i;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_state  <= S_MUL;
            end else begin
              r_result <= w_opResult;
              r_zero   <= (w_opResult == '0);
              r_err    <= w_opIllegal;
              r_valid  <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_accNext;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_lastIter) begin
            r_result <= w_accNext;
            r_zero   <= (w_accNext == '0);
            r_err    <= 1'b0;
            r_valid  <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (ready_i) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign result_o = r_result;
  assign zero_o   = r_zero;
  assign err_o    = r_err;
  assign valid_o  = r_valid;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed and randomized checks of alu_iter against an
// arithmetic reference model of the operation set and latencies.

module tb_alu_iter;

  localparam int WIDTH = 64;
  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             rstN;
  logic             validIn;
  logic             readyOut;
  logic [3:0]       aluCtrl;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [WIDTH-1:0] resultOut;
  logic             zeroOut;
  logic             errOut;
  logic             validOut;
  logic             readyIn;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] lastResult;
  logic             lastZero;
  logic             lastErr;

  alu_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_i     (clk),
    .rst_i     (rstN),
    .valid_i   (validIn),
    .ready_o   (readyOut),
    .ALUCtrl_i (aluCtrl),
    .src1_i    (src1),
    .src2_i    (src2),
    .result_o  (resultOut),
    .zero_o    (zeroOut),
    .err_o     (errOut),
    .valid_o   (validOut),
    .ready_i   (readyIn)
  );

  // Free-running clock with rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Behavioural model of the operation set in plain arithmetic
  function automatic void refModel(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, output logic [WIDTH-1:0] res,
                                   output logic err, output int lat);
    res = '0;
    err = 1'b0;
    lat = 1;
    case (op)
      4'b0000: res = a & b;
      4'b0001: res = a | b;
      4'b0010: res = a + b;
      4'b0110: res = a - b;
      4'b0111: res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'b1000: begin res = a * b; lat = WIDTH + 1; end
      default: err = 1'b1;
    endcase
  endfunction

  // Single comparison point: counts it and reports a failure with its tag
  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs,
                             input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for ready_o, present a request for one edge, then scramble the inputs
  task automatic applyStimulus(input logic [3:0] op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b);
    int n = 0;
    while (!readyOut && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_ready", {63'b0, readyOut}, 64'd1);
    aluCtrl = op;
    src1    = a;
    src2    = b;
    validIn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    validIn = 1'b0;
    src1    = {$urandom(), $urandom()};
    src2    = {$urandom(), $urandom()};
    aluCtrl = 4'($urandom_range(0, 15));
  endtask

  // Number of edges from the accept edge (counted as 1) until valid_o is seen; bounded
  task automatic waitResult(output int lat);
    lat = 1;
    while (!validOut && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Full transaction: accept, latency, result fields, optional backpressure, release
  task automatic runOp(input string tag, input logic [3:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input int holdCycles);
    logic [WIDTH-1:0] expRes;
    logic             expErr;
    int               expLat;
    int               lat;
    refModel(op, a, b, expRes, expErr, expLat);
    applyStimulus(op, a, b);
    waitResult(lat);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, "_valid"}, {63'b0, validOut}, 64'd1);
    checkOutput({tag, "_result"}, resultOut, expRes);
    checkOutput({tag, "_zero"}, {63'b0, zeroOut}, {63'b0, (expRes == '0)});
    checkOutput({tag, "_err"}, {63'b0, errOut}, {63'b0, expErr});
    lastResult = resultOut;
    lastZero   = zeroOut;
    lastErr    = errOut;
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      checkOutput({tag, "_hold_result"}, resultOut, expRes);
      checkOutput({tag, "_hold_valid"}, {63'b0, validOut}, 64'd1);
    end
    readyIn = 1'b1;
    @(negedge clk);
    readyIn = 1'b0;
    checkOutput({tag, "_release_valid"}, {63'b0, validOut}, 64'd0);
    checkOutput({tag, "_release_ready"}, {63'b0, readyOut}, 64'd1);
  endtask

  initial begin
    logic [3:0]       codes [6];
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sawValid;
    int               lat;

    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000};

    rstN    = 1'b0;
    validIn = 1'b0;
    readyIn = 1'b0;
    aluCtrl = 4'b0000;
    src1    = '0;
    src2    = '0;

    // Reset state
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    checkOutput("reset_ready", {63'b0, readyOut}, 64'd1);
    checkOutput("reset_valid", {63'b0, validOut}, 64'd0);
    checkOutput("reset_result", resultOut, 64'd0);
    checkOutput("reset_zero", {63'b0, zeroOut}, 64'd0);
    checkOutput("reset_err", {63'b0, errOut}, 64'd0);

    // Reset in the middle of a MUL discards it
    applyStimulus(4'b1000, 64'd7, 64'd9);
    repeat (10) @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    checkOutput("midmul_ready", {63'b0, readyOut}, 64'd1);
    checkOutput("midmul_valid", {63'b0, validOut}, 64'd0);
    checkOutput("midmul_result", resultOut, 64'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (validOut) sawValid = 1'b1;
    end
    checkOutput("midmul_no_valid", {63'b0, sawValid}, 64'd0);

    // ADD wraps to zero
    runOp("add_wrap", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
    checkOutput("add_wrap_const", lastResult, 64'd0);
    checkOutput("add_wrap_zero_const", {63'b0, lastZero}, 64'd1);

    // SUB and signed SLT
    runOp("sub", 4'b0110, 64'd5, 64'd7, 0);
    checkOutput("sub_const", lastResult, 64'hFFFF_FFFF_FFFF_FFFE);
    runOp("slt_neg", 4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
    checkOutput("slt_neg_const", lastResult, 64'd1);
    runOp("slt_pos", 4'b0111, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    checkOutput("slt_pos_const", lastResult, 64'd0);

    // MUL fixed latency and value, including a negative operand
    runOp("mul_a", 4'b1000, 64'h1_0000_0001, 64'h3, 0);
    checkOutput("mul_a_const", lastResult, 64'h3_0000_0003);
    runOp("mul_neg", 4'b1000, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 0);
    checkOutput("mul_neg_const", lastResult, 64'hFFFF_FFFF_FFFF_FFFA);

    // Backpressure: result held while inputs toggle
    applyStimulus(4'b0000, 64'hF0F0, 64'hFF00);
    waitResult(lat);
    checkOutput("bp_latency", 64'(lat), 64'd1);
    for (int i = 0; i < 5; i++) begin
      src1    = {$urandom(), $urandom()};
      validIn = ~validIn;
      @(negedge clk);
      checkOutput("bp_result", resultOut, 64'hF000);
      checkOutput("bp_valid", {63'b0, validOut}, 64'd1);
      checkOutput("bp_ready", {63'b0, readyOut}, 64'd0);
    end
    validIn = 1'b0;
    readyIn = 1'b1;
    @(negedge clk);
    readyIn = 1'b0;
    checkOutput("bp_idle_ready", {63'b0, readyOut}, 64'd1);
    checkOutput("bp_idle_valid", {63'b0, validOut}, 64'd0);

    // Illegal code followed by a legal OR
    runOp("illegal", 4'b1111, 64'd3, 64'd4, 0);
    checkOutput("illegal_err_const", {63'b0, lastErr}, 64'd1);
    checkOutput("illegal_zero_const", {63'b0, lastZero}, 64'd1);
    runOp("or_after", 4'b0001, 64'd1, 64'd2, 0);
    checkOutput("or_after_const", lastResult, 64'd3);
    checkOutput("or_after_err_const", {63'b0, lastErr}, 64'd0);

    // Randomized operations with random backpressure
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 6) == 0) begin
        op = 4'($urandom_range(0, 15));
        while (op == 4'b0000 || op == 4'b0001 || op == 4'b0010 ||
               op == 4'b0110 || op == 4'b0111 || op == 4'b1000) begin
          op = 4'($urandom_range(0, 15));
        end
      end else begin
        op = codes[$urandom_range(0, 5)];
      end
      case ($urandom_range(0, 5))
        0:       a = '0;
        1:       a = '1;
        default: a = {$urandom(), $urandom()};
      endcase
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = '1;
        default: b = {$urandom(), $urandom()};
      endcase
      runOp("rand", op, a, b, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
